dmem_line_ctrl: RTL and testbench

- Line-granular data memory behind the data cache; the cache's memory interface connects straight to it.
- Serves 256-bit line reads and write-backs with a fixed, parameterised access latency.
- Completion is signalled by a one-cycle acknowledge.
- Replaces the ideal single-cycle memory so miss and write-back timing is exercised realistically.

---
 rtl/dmem_line_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_line_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory with a fixed access latency and a one-cycle ack.
// One request outstanding; a TURN cycle after each ack absorbs a lingering enable.
module dmem_line_ctrl #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned IDX_W   = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         mem_enable_i,
    input  logic         mem_write_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [255:0] mem_data_i,
    output logic [255:0] mem_data_o,
    output logic         mem_ack_o,
    output logic         busy_o
);

    localparam int unsigned DEPTH    = 1 << IDX_W;
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    logic [255:0]     mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic [255:0]     wdata_q, wdata_d;
    logic [255:0]     rdata_q, rdata_d;

    logic [IDX_W-1:0] addr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_load;
    logic             unused_addr;

    assign addr_idx    = mem_addr_i[IDX_W+4:5];
    assign unused_addr = ^{mem_addr_i[31:IDX_W+5], mem_addr_i[4:0]};

    // With LATENCY=1 the read is captured on the accepting edge, before idx_q holds it.
    assign rd_idx = (state_q == S_IDLE) ? addr_idx : idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rd_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_enable_i) begin
                    idx_d   = addr_idx;
                    wr_d    = mem_write_i;
                    wdata_d = mem_data_i;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = S_ACK;
                        rd_load = ~mem_write_i;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_ACK;
                    rd_load = ~wr_q;
                end
            end
            S_ACK:   state_d = S_TURN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_load) begin
            rdata_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; a reset on the ACK edge still suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == S_ACK && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_data_o = rdata_q;
    assign mem_ack_o  = (state_q == S_ACK);
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed bench for dmem_line_ctrl: LATENCY=10 and LATENCY=1 instances checked
// every cycle against a timeline model of accepted requests.
module tb_dmem_line_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         en   [2];
    logic         wr   [2];
    logic [31:0]  addr [2];
    logic [255:0] wd   [2];
    logic [255:0] rd   [2];
    logic         ack  [2];
    logic         busy [2];

    always #5 clk = ~clk;

    dmem_line_ctrl #(.LATENCY(10), .IDX_W(10)) dut0 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[0]), .mem_write_i(wr[0]),
        .mem_addr_i(addr[0]), .mem_data_i(wd[0]), .mem_data_o(rd[0]),
        .mem_ack_o(ack[0]), .busy_o(busy[0])
    );

    dmem_line_ctrl #(.LATENCY(1), .IDX_W(10)) dut1 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[1]), .mem_write_i(wr[1]),
        .mem_addr_i(addr[1]), .mem_data_i(wd[1]), .mem_data_o(rd[1]),
        .mem_ack_o(ack[1]), .busy_o(busy[1])
    );

    int vec  = 0;
    int errs = 0;
    int pcnt = 0;
    bit started = 0;

    // Request timeline model: accepted at edge acc, ack in the interval after
    // edge acc+L-1, busy through edge acc+L, next acceptance from acc+L+2.
    int           LAT [2] = '{10, 1};
    bit           act [2];
    int           acc [2];
    int           next_ok [2];
    logic [31:0]  a_l [2];
    logic         w_l [2];
    logic [255:0] d_l [2];
    logic [255:0] exp_data [2];
    bit           exp_known [2];
    bit           e_ack [2];
    bit           e_busy [2];
    logic [255:0] mm [int];
    int           mp;
    int           key;

    int ackcnt [2] = '{0, 0};
    int last_ack_p [2] = '{-1, -1};

    always @(posedge clk) begin
        mp = pcnt;
        if (rst) started = 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act[k]       = 0;
                next_ok[k]   = mp + 1;
                exp_data[k]  = '0;
                exp_known[k] = 1;
            end else begin
                if (!act[k] && mp >= next_ok[k] && en[k] === 1'b1) begin
                    act[k] = 1; acc[k] = mp; next_ok[k] = mp + LAT[k] + 2;
                    a_l[k] = addr[k]; w_l[k] = wr[k]; d_l[k] = wd[k];
                end
                key = k * 4096 + int'((a_l[k] >> 5) % 1024);
                if (act[k] && mp == acc[k] + LAT[k] - 1 && !w_l[k]) begin
                    exp_known[k] = mm.exists(key);
                    if (exp_known[k]) exp_data[k] = mm[key];
                end
                if (act[k] && mp == acc[k] + LAT[k] && w_l[k]) mm[key] = d_l[k];
            end
            e_ack[k]  = act[k] && mp == acc[k] + LAT[k] - 1;
            e_busy[k] = act[k] && mp >= acc[k] && mp <= acc[k] + LAT[k];
            if (act[k] && mp >= acc[k] + LAT[k]) act[k] = 0;
        end
        pcnt = mp + 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (ack[k] !== e_ack[k]) begin
                    errs++;
                    $display("FAIL ack%0d @edge %0d: got %b expected %b", k, pcnt - 1, ack[k], e_ack[k]);
                end
                vec++;
                if (busy[k] !== e_busy[k]) begin
                    errs++;
                    $display("FAIL busy%0d @edge %0d: got %b expected %b", k, pcnt - 1, busy[k], e_busy[k]);
                end
                if (exp_known[k]) begin
                    vec++;
                    if (rd[k] !== exp_data[k]) begin
                        errs++;
                        $display("FAIL data%0d @edge %0d: got %h expected %h", k, pcnt - 1, rd[k], exp_data[k]);
                    end
                end
                if (ack[k] === 1'b1) begin
                    ackcnt[k]++;
                    last_ack_p[k] = pcnt - 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input int k, input int n0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (ackcnt[k] != n0) break;
        end
        if (ackcnt[k] == n0) chk("ack_timeout", 256'(ackcnt[k]), 256'(n0 + 1));
    endtask

    // Issue one request, scramble inputs after acceptance, wait for ack, return in IDLE.
    task automatic req(input int k, input logic w, input logic [31:0] a,
                       input logic [255:0] d, output int acc_o);
        int n0;
        en[k] = 1'b1; wr[k] = w; addr[k] = a; wd[k] = d;
        acc_o = pcnt; n0 = ackcnt[k];
        step(1);
        en[k] = 1'b0; wr[k] = ~w; addr[k] = 32'hFFFF_FFE0; wd[k] = ~d;
        wait_ack(k, n0);
        step(2);
    endtask

    localparam logic [255:0] A5  = {32{8'hA5}};
    localparam logic [255:0] L1V = {8{32'h1111_0001}};
    localparam logic [255:0] L2V = {8{32'h2222_0002}};
    localparam logic [255:0] V0  = {8{32'h0BAD_F00D}};
    localparam logic [255:0] V1  = {8{32'hC0DE_0001}};

    initial begin
        int a0, n0, p1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wd[k] = '0;
        end
        step(3);
        rst = 1'b0;
        chk("rst_ack", 256'(ack[0]), 256'd0);
        chk("rst_busy", 256'(busy[0]), 256'd0);
        chk("rst_data", rd[0], '0);

        req(0, 1'b1, 32'h60, A5, a0);
        req(0, 1'b1, 32'h20, L1V, a0);
        req(0, 1'b1, 32'h40, L2V, a0);

        req(0, 1'b0, 32'h60, '0, a0);
        chk("rd_latency", 256'(last_ack_p[0] - a0), 256'd9);
        chk("rd_data", rd[0], A5);

        req(0, 1'b1, 32'h80, 256'h1234, a0);
        req(0, 1'b0, 32'h80, '0, a0);
        chk("raw_data", rd[0], 256'h1234);
        req(0, 1'b0, 32'h60, '0, a0);
        chk("line3_kept", rd[0], A5);

        // Write-back then refill with enable held through the turnaround.
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h400; wd[0] = {8{32'h4444_0400}};
        n0 = ackcnt[0];
        step(1);
        wait_ack(0, n0);
        p1 = last_ack_p[0];
        wr[0] = 1'b0; addr[0] = 32'h20;
        step(3);
        en[0] = 1'b0;
        wait_ack(0, n0 + 1);
        chk("wb_gap", 256'(last_ack_p[0] - p1), 256'd12);
        chk("wb_refill_data", rd[0], L1V);
        step(15);
        chk("wb_ack_count", 256'(ackcnt[0] - n0), 256'd2);

        // Enable lingering one cycle after a read ack must be ignored.
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h60;
        n0 = ackcnt[0];
        step(1);
        wait_ack(0, n0);
        step(2);
        en[0] = 1'b0;
        step(12);
        chk("turn_busy", 256'(busy[0]), 256'd0);
        chk("turn_ack_count", 256'(ackcnt[0] - n0), 256'd1);

        // Reset during a write aborts it.
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40; wd[0] = {8{32'hDEAD_BEEF}};
        n0 = ackcnt[0];
        step(1);
        en[0] = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(15);
        chk("abort_noack", 256'(ackcnt[0]), 256'(n0));
        chk("abort_data0", rd[0], '0);
        chk("abort_busy", 256'(busy[0]), 256'd0);
        req(0, 1'b0, 32'h40, '0, a0);
        chk("abort_line2", rd[0], L2V);

        // LATENCY=1 instance.
        req(1, 1'b1, 32'h0, V0, a0);
        req(1, 1'b0, 32'h0, '0, a0);
        chk("l1_latency", 256'(last_ack_p[1] - a0), 256'd0);
        chk("l1_data", rd[1], V0);
        req(1, 1'b1, 32'h8000_0020, V1, a0);
        req(1, 1'b0, 32'h20, '0, a0);
        chk("l1_alias", rd[1], V1);
        req(1, 1'b0, 32'h0, '0, a0);
        chk("l1_line0_kept", rd[1], V0);

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
        $fatal(1, "watchdog");
    end

endmodule
